// File: rtl/i2s_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_fifo
//  Description : Synchronous transmit FIFO between the APB register block and
//                the I2S serializer. The register block pushes one Tx word per
//                single-cycle write strobe; the serializer pops one word per
//                audio channel slot. Status flags feed the register block's
//                flag word.
//
//  Ports
//    pclk          in   1        clock, all logic on rising edge
//    preset        in   1        asynchronous active-low reset
//    clr           in   1        synchronous flush (highest priority)
//    wr_en         in   1        push strobe
//    wr_data       in   DW       push data
//    rd_en         in   1        pop request
//    rd_data       out  DW       popped word, registered (1-cycle latency)
//    full          out  1        level == DEPTH
//    empty         out  1        level == 0
//    almost_full   out  1        level >= AF_THRESH
//    almost_empty  out  1        level <= AE_THRESH
//    level         out  LW       occupancy 0..DEPTH
//    overflow      out  1        sticky: push dropped while full
//    underflow     out  1        sticky: pop requested while empty
//    err_clr       in   1        synchronous clear of overflow/underflow
//
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_tx_fifo #(
    parameter int DW        = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] c_depth     = LW'(DEPTH);
    localparam logic [LW-1:0] c_af_thresh = LW'(AF_THRESH);
    localparam logic [LW-1:0] c_ae_thresh = LW'(AE_THRESH);

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [DW-1:0] r_rd_data;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_accept;
    logic          w_wr_accept;
    logic          w_ovf_set;
    logic          w_unf_set;

    // ------------------------------------------------------------------------
    // Flag decode. Pointers wrap naturally, so wr_ptr == rd_ptr is ambiguous;
    // the level counter is the only full/empty discriminator.
    // ------------------------------------------------------------------------
    always_comb begin
        w_full  = (r_level == c_depth);
        w_empty = (r_level == '0);
    end

    // A push into a full FIFO is still accepted when a pop frees the head slot
    // on the same edge. When full, wr_ptr == rd_ptr, and the non-blocking read
    // of r_mem returns the old head before the new word lands there.
    always_comb begin
        w_rd_accept = rd_en && !w_empty;
        w_wr_accept = wr_en && (!w_full || w_rd_accept);
        w_ovf_set   = wr_en && !w_wr_accept;
        w_unf_set   = rd_en && w_empty;
    end

    // ------------------------------------------------------------------------
    // Memory array: deliberately not reset; only slots between the pointers
    // are ever observed.
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (w_wr_accept && !clr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, level and read data
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else if (clr) begin
            // Flush discards any push or pop presented in the same cycle.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_accept) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags. A new error in the same cycle as err_clr wins.
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set || (r_overflow  && !err_clr);
            r_underflow <= w_unf_set || (r_underflow && !err_clr);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        rd_data      = r_rd_data;
        level        = r_level;
        full         = w_full;
        empty        = w_empty;
        almost_full  = (r_level >= c_af_thresh);
        almost_empty = (r_level <= c_ae_thresh);
        overflow     = r_overflow;
        underflow    = r_underflow;
    end

endmodule
`default_nettype wire
